multimem_8w16r: RTL and testbench
=================================

Name: multimem_8w16r

Overview:
- Single-clock simple dual-port RAM with asymmetric widths.
- Port A is write-only: 4096 x 8-bit.
- Port B is read-only: 2048 x 16-bit over the same storage.
- Sits between a byte-wide loader (e.g. UART/command writer) and a 16-bit pixel/frame reader in the LED display path.

Parameters:
- ADDR_WIDTH_A, 12, byte address width of port A. Depth is 2**ADDR_WIDTH_A bytes.
- DATA_WIDTH_A, 8, port A data width.
- Derived, not overridable: ADDR_WIDTH_B = ADDR_WIDTH_A-1, DATA_WIDTH_B = 2*DATA_WIDTH_A.

Ports:
- clk  input  1  single clock for both ports; all activity on rising edge.
- reset  input  1  asynchronous, active-low reset.
- DataInA  input  8  write data.
- AddressA  input  12  byte write address.
- ClockEnA  input  1  port A enable.
- WrA  input  1  write strobe; qualified by ClockEnA.
- AddressB  input  11  16-bit word read address.
- ClockEnB  input  1  port B read enable.
- QB  output  16  registered read data.

Behaviour:
- Storage: 4096 bytes, mem[0..4095]. Contents initialise to all zeros at configuration/simulation start. Reset does not clear contents.
- Write: on rising clk with ClockEnA=1 and WrA=1, mem[AddressA] <= DataInA.
  - ClockEnA=0 or WrA=0 means no write.
  - Writes are allowed while reset is asserted.
- Word mapping: word w = {mem[2w+1], mem[2w]}.
  - QB[15:8] comes from the odd byte address (AddressA[0]=1).
  - QB[7:0] comes from the even byte address (AddressA[0]=0).
- Read: on rising clk with ClockEnB=1 and reset high, QB <= word[AddressB].
  - Latency is 1 clock from address/enable sampled to QB valid.
  - ClockEnB=0 means QB holds its previous value.
- Reset: reset=0 forces QB to 16'h0000 immediately, asynchronously, and holds it while low. Reads resume on the first rising edge after release.
- Collision: a same-cycle write to either byte of the word being read is read-before-write.
  - QB returns the pre-write data for that edge.
  - The new data is visible on the next enabled read.
- No handshake and no busy state. One write and one read may occur every cycle.
- Address wrap: none needed. Full address ranges map 1:1. Top word 0x7FF covers bytes 0xFFE/0xFFF.
- No X propagation from unwritten locations, because of the zero init.

Test Plan:
- Reset then idle: assert reset low mid-simulation -> QB=16'h0000 asynchronously. ClockEnB=1 with reset low -> QB stays 0.
- Byte writes then word read: write 0xFFF="A"(0x41) and 0xFFE="B"(0x42). Next cycle read AddressB=0x7FF with ClockEnB=1 -> QB=16'h4142 one clock later.
- Single-byte overwrite: write 0xFFF="C". Then read 0x7FF -> QB=16'h4342, low byte untouched.
- Back-to-back and collision, all every cycle reading 0x7FF:
  - Cycle 0: write 0xFFF="D".
  - Cycle 1: write 0xFFE="E".
  - Cycle 2: write 0xFFE="F".
  - QB after cycles 1, 2, 3 = 16'h4442, 16'h4445, 16'h4446 (read-before-write).
- Mid-range address: same sequence at byte 0x7FF="Z", 0x7FE="Y" then "R", reading word 0x3FF -> QB progresses to 16'h5A52. Words 0x7FF/0xFFF regions unchanged (re-read 0x7FF -> 16'h4446).
- Enable gating:
  - WrA=1 with ClockEnA=0 -> no write; a later read shows the old data.
  - ClockEnB=0 while AddressB changes -> QB holds.

Source files
------------

// File: rtl/multimem_8w16r_if.sv
// Port bundle for the 8-bit write / 16-bit read RAM. The loader drives the
// master side and the RAM is the slave. QB is the registered read data.
interface multimem_8w16r_if #(
    parameter int ADDR_WIDTH_A = 12,
    parameter int DATA_WIDTH_A = 8
);
    localparam int ADDR_WIDTH_B = ADDR_WIDTH_A - 1;
    localparam int DATA_WIDTH_B = 2 * DATA_WIDTH_A;

    logic [DATA_WIDTH_A-1:0] DataInA;
    logic [ADDR_WIDTH_A-1:0] AddressA;
    logic                    ClockEnA;
    logic                    WrA;
    logic [ADDR_WIDTH_B-1:0] AddressB;
    logic                    ClockEnB;
    logic [DATA_WIDTH_B-1:0] QB;

    modport master (
        output DataInA, AddressA, ClockEnA, WrA, AddressB, ClockEnB,
        input  QB
    );

    modport slave (
        input  DataInA, AddressA, ClockEnA, WrA, AddressB, ClockEnB,
        output QB
    );
endinterface

// File: rtl/multimem_8w16r.sv
// Simple dual-port RAM: byte-wide write port A, word-wide read port B.
// Storage is split into an even-byte bank and an odd-byte bank that are read together.
module multimem_8w16r_bank #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    // Zero initial contents; reset never clears the array.
    logic [DW-1:0] mem [0:(2**AW)-1] = '{default: '0};
    logic [DW-1:0] rd_d, rd_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read samples the array before this edge's write lands: read-before-write.
    always_comb begin
        rd_d = rd_q;
        if (re) rd_d = mem[raddr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_q <= '0;
        else        rd_q <= rd_d;
    end

    assign rdata = rd_q;
endmodule

module multimem_8w16r #(
    parameter int ADDR_WIDTH_A = 12,
    parameter int DATA_WIDTH_A = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    multimem_8w16r_if.slave       bus
);
    localparam int NUM_LANES    = 2;
    localparam int ADDR_WIDTH_B = ADDR_WIDTH_A - 1;

    logic                                      wr_en;
    logic [NUM_LANES-1:0][DATA_WIDTH_A-1:0]    lane_rd;

    assign wr_en = bus.ClockEnA & bus.WrA;

    // Lane 0 holds even byte addresses (QB low byte), lane 1 the odd ones.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        multimem_8w16r_bank #(
            .AW (ADDR_WIDTH_B),
            .DW (DATA_WIDTH_A)
        ) u_bank (
            .clk   (clk),
            .reset (reset),
            .we    (wr_en && (bus.AddressA[0] == (l == 1))),
            .waddr (bus.AddressA[ADDR_WIDTH_A-1:1]),
            .wdata (bus.DataInA),
            .re    (bus.ClockEnB),
            .raddr (bus.AddressB),
            .rdata (lane_rd[l])
        );
    end

    assign bus.QB = lane_rd;
endmodule

// File: tb/tb_multimem_8w16r.sv
// Directed bench for multimem_8w16r: byte writes, word reads, collisions,
// enable gating and asynchronous reset of the read register.
module tb_multimem_8w16r;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multimem_8w16r_if #(.ADDR_WIDTH_A(12), .DATA_WIDTH_A(8)) bus ();

    multimem_8w16r #(.ADDR_WIDTH_A(12), .DATA_WIDTH_A(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, clock it, then settle just past the edge.
    task automatic step(input logic cea, input logic wra, input logic [11:0] aa,
                        input logic [7:0] da, input logic ceb, input logic [10:0] ab);
        bus.ClockEnA = cea;
        bus.WrA      = wra;
        bus.AddressA = aa;
        bus.DataInA  = da;
        bus.ClockEnB = ceb;
        bus.AddressB = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.ClockEnA = 0; bus.WrA = 0; bus.AddressA = '0; bus.DataInA = '0;
        bus.ClockEnB = 0; bus.AddressB = '0;
        #1;
        checks++;
        if (bus.QB !== 16'h0000) begin
            errors++; $display("FAIL reset_init got %h exp %h", bus.QB, 16'h0000);
        end
        step(0, 0, 12'h000, 8'h00, 1, 11'h000);
        checks++;
        if (bus.QB !== 16'h0000) begin
            errors++; $display("FAIL reset_read_held got %h exp %h", bus.QB, 16'h0000);
        end
        reset = 1'b1;
        step(0, 0, 12'h000, 8'h00, 1, 11'h000);
        checks++;
        if (bus.QB !== 16'h0000) begin
            errors++; $display("FAIL zero_init_word0 got %h exp %h", bus.QB, 16'h0000);
        end
    endtask

    task automatic test_byte_write();
        step(1, 1, 12'hFFF, 8'h41, 0, 11'h000);
        step(1, 1, 12'hFFE, 8'h42, 0, 11'h000);
        step(0, 0, 12'h000, 8'h00, 1, 11'h7FF);
        checks++;
        if (bus.QB !== 16'h4142) begin
            errors++; $display("FAIL byte_write_read got %h exp %h", bus.QB, 16'h4142);
        end
    endtask

    task automatic test_overwrite();
        step(1, 1, 12'hFFF, 8'h43, 0, 11'h000);
        step(0, 0, 12'h000, 8'h00, 1, 11'h7FF);
        checks++;
        if (bus.QB !== 16'h4342) begin
            errors++; $display("FAIL single_byte_overwrite got %h exp %h", bus.QB, 16'h4342);
        end
    endtask

    task automatic test_back_to_back();
        step(1, 1, 12'hFFF, 8'h44, 1, 11'h7FF);
        checks++;
        if (bus.QB !== 16'h4342) begin
            errors++; $display("FAIL b2b_cycle0 got %h exp %h", bus.QB, 16'h4342);
        end
        step(1, 1, 12'hFFE, 8'h45, 1, 11'h7FF);
        checks++;
        if (bus.QB !== 16'h4442) begin
            errors++; $display("FAIL b2b_cycle1 got %h exp %h", bus.QB, 16'h4442);
        end
        step(1, 1, 12'hFFE, 8'h46, 1, 11'h7FF);
        checks++;
        if (bus.QB !== 16'h4445) begin
            errors++; $display("FAIL b2b_cycle2 got %h exp %h", bus.QB, 16'h4445);
        end
        step(0, 0, 12'h000, 8'h00, 1, 11'h7FF);
        checks++;
        if (bus.QB !== 16'h4446) begin
            errors++; $display("FAIL b2b_cycle3 got %h exp %h", bus.QB, 16'h4446);
        end
    endtask

    task automatic test_mid_range();
        step(1, 1, 12'h7FF, 8'h5A, 1, 11'h3FF);
        checks++;
        if (bus.QB !== 16'h0000) begin
            errors++; $display("FAIL mid_cycle0 got %h exp %h", bus.QB, 16'h0000);
        end
        step(1, 1, 12'h7FE, 8'h59, 1, 11'h3FF);
        checks++;
        if (bus.QB !== 16'h5A00) begin
            errors++; $display("FAIL mid_cycle1 got %h exp %h", bus.QB, 16'h5A00);
        end
        step(1, 1, 12'h7FE, 8'h52, 1, 11'h3FF);
        checks++;
        if (bus.QB !== 16'h5A59) begin
            errors++; $display("FAIL mid_cycle2 got %h exp %h", bus.QB, 16'h5A59);
        end
        step(0, 0, 12'h000, 8'h00, 1, 11'h3FF);
        checks++;
        if (bus.QB !== 16'h5A52) begin
            errors++; $display("FAIL mid_cycle3 got %h exp %h", bus.QB, 16'h5A52);
        end
        step(0, 0, 12'h000, 8'h00, 1, 11'h7FF);
        checks++;
        if (bus.QB !== 16'h4446) begin
            errors++; $display("FAIL mid_top_untouched got %h exp %h", bus.QB, 16'h4446);
        end
    endtask

    task automatic test_enable_gating();
        step(0, 1, 12'hFFF, 8'h00, 1, 11'h7FF);
        step(0, 0, 12'h000, 8'h00, 1, 11'h7FF);
        checks++;
        if (bus.QB !== 16'h4446) begin
            errors++; $display("FAIL cea_gates_write got %h exp %h", bus.QB, 16'h4446);
        end
        step(1, 0, 12'hFFE, 8'h11, 1, 11'h7FF);
        step(0, 0, 12'h000, 8'h00, 1, 11'h7FF);
        checks++;
        if (bus.QB !== 16'h4446) begin
            errors++; $display("FAIL wra_gates_write got %h exp %h", bus.QB, 16'h4446);
        end
        step(0, 0, 12'h000, 8'h00, 0, 11'h3FF);
        checks++;
        if (bus.QB !== 16'h4446) begin
            errors++; $display("FAIL ceb_hold_a got %h exp %h", bus.QB, 16'h4446);
        end
        step(0, 0, 12'h000, 8'h00, 0, 11'h000);
        checks++;
        if (bus.QB !== 16'h4446) begin
            errors++; $display("FAIL ceb_hold_b got %h exp %h", bus.QB, 16'h4446);
        end
    endtask

    task automatic test_async_reset();
        step(0, 0, 12'h000, 8'h00, 1, 11'h3FF);
        checks++;
        if (bus.QB !== 16'h5A52) begin
            errors++; $display("FAIL pre_reset_read got %h exp %h", bus.QB, 16'h5A52);
        end
        // Assert reset between clock edges; QB must clear without an edge.
        #1 reset = 1'b0;
        #1;
        checks++;
        if (bus.QB !== 16'h0000) begin
            errors++; $display("FAIL async_reset_clear got %h exp %h", bus.QB, 16'h0000);
        end
        step(1, 1, 12'hFFE, 8'h47, 1, 11'h7FF);
        checks++;
        if (bus.QB !== 16'h0000) begin
            errors++; $display("FAIL reset_holds_qb got %h exp %h", bus.QB, 16'h0000);
        end
        reset = 1'b1;
        step(0, 0, 12'h000, 8'h00, 1, 11'h7FF);
        checks++;
        if (bus.QB !== 16'h4447) begin
            errors++; $display("FAIL write_during_reset got %h exp %h", bus.QB, 16'h4447);
        end
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_overwrite();
        test_back_to_back();
        test_mid_range();
        test_enable_gating();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
